// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and helpers for the FIFO write-port arbiter
package fifo_arb_pkg;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int IDX_W  = 3;
    localparam int MAX_N  = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    // Callers zero-extend req_data to the full eight-lane width before passing it in.
    function automatic logic [DATA_W-1:0] get_lane(
        input logic [MAX_N*DATA_W-1:0] data,
        input logic [IDX_W-1:0]        idx
    );
        return data[{idx, 3'b000} +: DATA_W];
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - round-robin pick: first set request at or above ptr, wrapping
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 3
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    output logic             o_found,
    output logic [IDX_W-1:0] o_idx
);

    localparam logic [IDX_W:0] N_W = (IDX_W + 1)'(N);

    logic [2*N-1:0]   w_dbl;
    logic [N-1:0]     w_rot;
    logic [IDX_W-1:0] w_off;
    logic [IDX_W:0]   w_sum;

    always_comb begin
        w_dbl   = {i_req, i_req} >> i_ptr;
        w_rot   = w_dbl[N-1:0];
        o_found = 1'b0;
        w_off   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_off   = IDX_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= N_W) begin
            w_sum = w_sum - N_W;
        end
        o_idx = w_sum[IDX_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter driving a registered FIFO write port
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N            = 4,
    parameter int DEPTH        = 8,
    parameter int AFULL_LEVEL  = 7,
    parameter int MAX_BURST    = 4,
    parameter int IDLE_TIMEOUT = 3
) (
    input  logic                  i_wr_clk,
    input  logic                  i_rst,
    input  logic [N-1:0]          i_req_valid,
    input  logic [N*DATA_W-1:0]   i_req_data,
    input  logic [N-1:0]          i_req_last,
    output logic [N-1:0]          o_req_ready,
    output logic                  o_wr_en,
    output logic [DATA_W-1:0]     o_wdata,
    input  logic                  i_full,
    input  logic [CNT_W-1:0]      i_fifo_counter,
    output logic                  o_grant_active,
    output logic [IDX_W-1:0]      o_grant_id
);

    localparam logic [CNT_W:0]   AFULL_W = (CNT_W + 1)'(AFULL_LEVEL);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0] MAXB_W  = CNT_W'(MAX_BURST);
    localparam logic [CNT_W-1:0] TO_W    = CNT_W'(IDLE_TIMEOUT);

    state_t           r_state, w_state_nx;
    logic [IDX_W-1:0] r_ptr, w_ptr_nx;
    logic [IDX_W-1:0] r_grant_id, w_grant_id_nx;
    logic [CNT_W-1:0] r_beat_cnt, w_beat_cnt_nx;
    logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nx;
    logic             r_wr_en;
    logic [DATA_W-1:0] r_wdata;

    logic             w_found;
    logic [IDX_W-1:0] w_pick;
    logic [CNT_W:0]   w_occ;
    logic             w_stop;
    logic [N-1:0]     w_ready;
    logic             w_valid_g, w_last_g;
    logic             w_beat, w_idle_tick, w_end;
    logic [IDX_W-1:0] w_ptr_inc;
    logic [DATA_W-1:0] w_lane;

    rr_pick #(.N(N), .IDX_W(IDX_W)) u_rr_pick (
        .i_req   (i_req_valid),
        .i_ptr   (r_ptr),
        .o_found (w_found),
        .o_idx   (w_pick)
    );

    // The write already in flight counts toward occupancy; the depth term guards odd AFULL settings.
    assign w_occ  = {1'b0, i_fifo_counter} + {{CNT_W{1'b0}}, r_wr_en};
    assign w_stop = i_full | (w_occ >= AFULL_W) | (w_occ > DEPTH_W);
    assign w_lane = get_lane((MAX_N * DATA_W)'(i_req_data), r_grant_id);

    always_comb begin
        w_ready   = '0;
        w_valid_g = 1'b0;
        w_last_g  = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (r_grant_id == IDX_W'(i)) begin
                w_ready[i] = (r_state == BURST) && !w_stop;
                w_valid_g  = i_req_valid[i];
                w_last_g   = i_req_last[i];
            end
        end
    end

    assign w_beat      = (r_state == BURST) && !w_stop && w_valid_g;
    assign w_idle_tick = (r_state == BURST) && !w_stop && !w_valid_g;
    assign w_end       = (w_beat && (w_last_g || (r_beat_cnt + CNT_W'(1) == MAXB_W)))
                       || (w_idle_tick && (r_to_cnt + CNT_W'(1) == TO_W));
    assign w_ptr_inc   = (r_grant_id == IDX_W'(N - 1)) ? '0 : r_grant_id + IDX_W'(1);

    always_comb begin
        w_state_nx    = r_state;
        w_ptr_nx      = r_ptr;
        w_grant_id_nx = r_grant_id;
        w_beat_cnt_nx = r_beat_cnt;
        w_to_cnt_nx   = r_to_cnt;
        if (r_state == IDLE) begin
            if (w_found) begin
                w_grant_id_nx = w_pick;
                w_state_nx    = BURST;
            end
        end else begin
            if (w_beat) begin
                w_beat_cnt_nx = r_beat_cnt + CNT_W'(1);
                w_to_cnt_nx   = '0;
            end else if (w_idle_tick) begin
                w_to_cnt_nx = r_to_cnt + CNT_W'(1);
            end
            if (w_end) begin
                w_state_nx    = IDLE;
                w_ptr_nx      = w_ptr_inc;
                w_beat_cnt_nx = '0;
                w_to_cnt_nx   = '0;
            end
        end
    end

    always_ff @(posedge i_wr_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_grant_id <= '0;
            r_beat_cnt <= '0;
            r_to_cnt   <= '0;
            r_wr_en    <= 1'b0;
            r_wdata    <= '0;
        end else begin
            r_state    <= w_state_nx;
            r_ptr      <= w_ptr_nx;
            r_grant_id <= w_grant_id_nx;
            r_beat_cnt <= w_beat_cnt_nx;
            r_to_cnt   <= w_to_cnt_nx;
            r_wr_en    <= w_beat;
            if (w_beat) begin
                r_wdata <= w_lane;
            end
        end
    end

    assign o_req_ready    = w_ready;
    assign o_wr_en        = r_wr_en;
    assign o_wdata        = r_wdata;
    assign o_grant_active = (r_state == BURST);
    assign o_grant_id     = r_grant_id;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - self-checking bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int N    = 4;
    localparam int MAXB = 4;
    localparam int TO   = 3;
    localparam int AF   = 7;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [N-1:0]   valid = '0;
    logic [N-1:0]   last = '0;
    logic [N*8-1:0] data = '0;
    logic           full = 1'b0;
    logic [3:0]     cnt = '0;
    logic [N-1:0]   ready;
    logic           wr_en;
    logic [7:0]     wdata;
    logic           gact;
    logic [2:0]     gid;

    int passed = 0;
    int total  = 0;

    logic [8:0] pq[N][$];
    logic [8:0] mq[N][$];
    logic [7:0] exp_writes[$];
    int         exp_grants[$];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .N(N), .DEPTH(8), .AFULL_LEVEL(AF), .MAX_BURST(MAXB), .IDLE_TIMEOUT(TO)
    ) dut (
        .i_wr_clk(clk), .i_rst(rst), .i_req_valid(valid), .i_req_data(data),
        .i_req_last(last), .o_req_ready(ready), .o_wr_en(wr_en), .o_wdata(wdata),
        .i_full(full), .i_fifo_counter(cnt), .o_grant_active(gact), .o_grant_id(gid)
    );

    task automatic next_cycle;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        valid = '0; last = '0; data = '0; full = 1'b0; cnt = '0;
        rst = 1'b1;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; valid = '1; data = 32'hDEADBEEF;
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++; if (wr_en !== 1'b0) $display("FAIL reset_wr_en: got %b want 0", wr_en); else passed++;
        total++; if (wdata !== 8'h00) $display("FAIL reset_wdata: got %h want 00", wdata); else passed++;
        total++; if (ready !== 4'b0000) $display("FAIL reset_ready: got %b want 0000", ready); else passed++;
        total++; if (gact !== 1'b0) $display("FAIL reset_grant_active: got %b want 0", gact); else passed++;
        total++; if (gid !== 3'd0) $display("FAIL reset_grant_id: got %0d want 0", gid); else passed++;
        rst = 1'b0; valid = '0; data = '0;
        next_cycle();
    endtask

    task automatic test_single;
        do_reset();
        valid[0] = 1'b1; data[7:0] = 8'hA1;
        @(negedge clk);
        total++; if (ready !== 4'b0000) $display("FAIL single_idle_ready: got %b want 0000", ready); else passed++;
        next_cycle();
        for (int b = 0; b < 3; b++) begin
            data[7:0] = 8'(8'hA1 + b);
            last[0] = (b == 2);
            @(negedge clk);
            total++; if (ready !== 4'b0001) $display("FAIL single_ready beat%0d: got %b want 0001", b, ready); else passed++;
            total++; if (wr_en !== (b > 0)) $display("FAIL single_wr_en beat%0d: got %b want %b", b, wr_en, (b > 0)); else passed++;
            if (b > 0) begin
                total++;
                if (wdata !== 8'(8'hA1 + b - 1)) $display("FAIL single_wdata beat%0d: got %h want %h", b, wdata, 8'(8'hA1 + b - 1));
                else passed++;
            end
            next_cycle();
        end
        valid = '0; last = '0;
        @(negedge clk);
        total++; if (wr_en !== 1'b1 || wdata !== 8'hA3) $display("FAIL single_last_write: got %b/%h want 1/a3", wr_en, wdata); else passed++;
        total++; if (gact !== 1'b0) $display("FAIL single_release: got %b want 0", gact); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (wr_en !== 1'b0) $display("FAIL single_wr_en_after: got %b want 0", wr_en); else passed++;
        next_cycle();
    endtask

    task automatic test_round_robin;
        logic       exp_act;
        logic       exp_wr;
        int         exp_g;
        logic [N-1:0] exp_r;
        do_reset();
        valid = '1; data = 32'h33221100;
        for (int t = 0; t < 25; t++) begin
            exp_act = (t % 5) != 0;
            exp_g   = (t / 5) % N;
            exp_wr  = (t > 0) && ((t % 5) != 1);
            exp_r   = exp_act ? N'(1 << exp_g) : '0;
            @(negedge clk);
            total++; if (gact !== exp_act) $display("FAIL rr_active t%0d: got %b want %b", t, gact, exp_act); else passed++;
            if (exp_act) begin
                total++; if (gid !== 3'(exp_g)) $display("FAIL rr_grant t%0d: got %0d want %0d", t, gid, exp_g); else passed++;
            end
            total++; if (ready !== exp_r) $display("FAIL rr_ready t%0d: got %b want %b", t, ready, exp_r); else passed++;
            total++; if (wr_en !== exp_wr) $display("FAIL rr_wr_en t%0d: got %b want %b", t, wr_en, exp_wr); else passed++;
            next_cycle();
        end
        valid = '0;
    endtask

    task automatic test_throttle;
        do_reset();
        valid[0] = 1'b1; data[7:0] = 8'h55;
        next_cycle();
        @(negedge clk);
        total++; if (ready !== 4'b0001) $display("FAIL thr_first_ready: got %b want 0001", ready); else passed++;
        next_cycle();
        cnt = 4'd6;
        @(negedge clk);
        total++; if (wr_en !== 1'b1) $display("FAIL thr_inflight: got %b want 1", wr_en); else passed++;
        total++; if (ready !== 4'b0000) $display("FAIL thr_afull_ready: got %b want 0000", ready); else passed++;
        next_cycle();
        cnt = 4'd5; valid = '0;
        @(negedge clk);
        total++; if (ready !== 4'b0001) $display("FAIL thr_below_ready: got %b want 0001", ready); else passed++;
        next_cycle();
        cnt = 4'd0; full = 1'b1;
        for (int k = 0; k < 10; k++) begin
            valid[0] = (k < 5);
            @(negedge clk);
            total++; if (ready !== 4'b0000) $display("FAIL thr_full_ready k%0d: got %b want 0000", k, ready); else passed++;
            total++; if (wr_en !== 1'b0) $display("FAIL thr_full_wr_en k%0d: got %b want 0", k, wr_en); else passed++;
            total++; if (gact !== 1'b1) $display("FAIL thr_full_hold k%0d: got %b want 1", k, gact); else passed++;
            next_cycle();
        end
        full = 1'b0; valid = '0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (gact !== (k < 2)) $display("FAIL thr_timeout k%0d: got %b want %b", k, gact, (k < 2)); else passed++;
            next_cycle();
        end
    endtask

    task automatic test_timeout;
        do_reset();
        valid = 4'b0110; data = 32'h00221100;
        @(negedge clk);
        total++; if (gact !== 1'b0) $display("FAIL to_idle: got %b want 0", gact); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (gid !== 3'd1 || ready !== 4'b0010) $display("FAIL to_grant1: got %0d/%b want 1/0010", gid, ready); else passed++;
        next_cycle();
        valid[1] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            total++; if (gact !== 1'b1 || ready !== 4'b0010) $display("FAIL to_hold k%0d: got %b/%b want 1/0010", k, gact, ready); else passed++;
            next_cycle();
        end
        @(negedge clk);
        total++; if (gact !== 1'b0) $display("FAIL to_release: got %b want 0", gact); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (gact !== 1'b1 || gid !== 3'd2) $display("FAIL to_next_grant: got %b/%0d want 1/2", gact, gid); else passed++;
        valid = '0;
        next_cycle();
    endtask

    task automatic test_reset_mid_burst;
        do_reset();
        valid = 4'b0010; last = 4'b0010; data = 32'h44332211;
        next_cycle();
        next_cycle();
        valid = 4'b0001; last = '0;
        next_cycle();
        rst = 1'b1;
        @(negedge clk);
        total++; if (ready !== 4'b0001) $display("FAIL rstm_beat_ready: got %b want 0001", ready); else passed++;
        next_cycle();
        rst = 1'b0; valid = 4'b0101;
        @(negedge clk);
        total++; if (wr_en !== 1'b0) $display("FAIL rstm_wr_en: got %b want 0", wr_en); else passed++;
        total++; if (ready !== 4'b0000) $display("FAIL rstm_ready: got %b want 0000", ready); else passed++;
        total++; if (gact !== 1'b0) $display("FAIL rstm_active: got %b want 0", gact); else passed++;
        next_cycle();
        @(negedge clk);
        total++; if (gact !== 1'b1 || gid !== 3'd0) $display("FAIL rstm_regrant: got %b/%0d want 1/0", gact, gid); else passed++;
        valid = '0;
        next_cycle();
    endtask

    task automatic test_random_traffic;
        int           ptr, g, n, lane, cycles, cur_g;
        logic [8:0]   b;
        logic         stop, acc, prev_acc, prev_act, any;
        logic [N-1:0] exp_r;
        logic [7:0]   ew;
        do_reset();
        exp_writes.delete();
        exp_grants.delete();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            for (int p = 0; p < int'($urandom_range(1, 3)); p++) begin
                n = $urandom_range(1, 6);
                for (int j = 0; j < n; j++) pq[i].push_back({(j == n - 1), 8'($urandom)});
            end
            mq[i] = pq[i];
        end
        ptr = 0;
        forever begin
            g = -1;
            for (int k = N - 1; k >= 0; k--) if (mq[(ptr + k) % N].size() > 0) g = (ptr + k) % N;
            if (g < 0) break;
            exp_grants.push_back(g);
            n = 0;
            do begin
                b = mq[g].pop_front();
                exp_writes.push_back(b[7:0]);
                n++;
            end while (!b[8] && n < MAXB);
            ptr = (g + 1) % N;
        end
        prev_acc = 1'b0; prev_act = 1'b0; cur_g = 0; cycles = 0;
        any = 1'b1;
        while (cycles < 3000 && (any || prev_acc)) begin
            for (int i = 0; i < N; i++) begin
                valid[i] = pq[i].size() > 0;
                data[i*8 +: 8] = valid[i] ? pq[i][0][7:0] : 8'h00;
                last[i] = valid[i] ? pq[i][0][8] : 1'b0;
            end
            full = ($urandom_range(0, 7) == 0);
            cnt  = 4'($urandom_range(0, 8));
            @(negedge clk);
            stop = full || ((int'(cnt) + int'(prev_acc)) >= AF);
            if (gact && !prev_act) begin
                total++;
                if (exp_grants.size() == 0) $display("FAIL rnd_grant: got %0d want none", gid);
                else begin
                    cur_g = exp_grants.pop_front();
                    if (gid !== 3'(cur_g)) $display("FAIL rnd_grant: got %0d want %0d", gid, cur_g); else passed++;
                end
            end
            exp_r = (gact && !stop) ? N'(1 << cur_g) : '0;
            total++; if (ready !== exp_r) $display("FAIL rnd_ready c%0d: got %b want %b", cycles, ready, exp_r); else passed++;
            total++; if (wr_en !== prev_acc) $display("FAIL rnd_wr_en c%0d: got %b want %b", cycles, wr_en, prev_acc); else passed++;
            if (prev_acc) begin
                ew = (exp_writes.size() > 0) ? exp_writes.pop_front() : 8'hxx;
                total++; if (wdata !== ew) $display("FAIL rnd_wdata c%0d: got %h want %h", cycles, wdata, ew); else passed++;
            end
            acc = |(ready & valid);
            lane = -1;
            for (int i = 0; i < N; i++) if (ready[i] && valid[i]) lane = i;
            prev_act = gact;
            next_cycle();
            if (lane >= 0) void'(pq[lane].pop_front());
            prev_acc = acc;
            any = 1'b0;
            for (int i = 0; i < N; i++) if (pq[i].size() > 0) any = 1'b1;
            cycles++;
        end
        valid = '0; last = '0; full = 1'b0; cnt = '0;
        total++; if (exp_writes.size() != 0) $display("FAIL rnd_writes_left: got %0d want 0", exp_writes.size()); else passed++;
        total++; if (exp_grants.size() != 0) $display("FAIL rnd_grants_left: got %0d want 0", exp_grants.size()); else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_throttle();
        test_timeout();
        test_reset_mid_burst();
        for (int r = 0; r < 4; r++) test_random_traffic();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
